// File: rtl/nibble_seq_adder_pkg.sv
// Shared types for the nibble-serial add controller.
// Combinational only; no latency.
// No flow control of its own.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/nibble_seq_adder_if.sv
// Operand, adder-side and result signals of the nibble-serial adder.
// No logic; no latency.
// Valid/ready on the operand and result sides; the adder side is combinational.
interface nibble_seq_adder_if #(
    parameter int NIBBLES = 4
);
    import nibble_add_pkg::*;

    localparam int W = NIBBLE_W * NIBBLES;

    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_a;
    logic [W-1:0]        in_b;
    logic                in_cin;

    logic [NIBBLE_W-1:0] add_a;
    logic [NIBBLE_W-1:0] add_b;
    logic                add_cin;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;

    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_sum;
    logic                out_cout;
    logic                out_ovf;
    logic                busy;

    // Environment side: supplies operands, the adder return and result acceptance.
    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );

    // Controller side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );

endinterface

// File: rtl/adder_1c.sv
// 4-bit ripple-carry adder used one nibble at a time by the sequencer.
// Purely combinational.
// No flow control.
module adder_1c (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/nibble_seq_adder.sv
// Drives a 4-bit adder one nibble per cycle (LSB first) to add two W-bit operands.
// Latency: result valid NIBBLES edges after the accept edge.
// Result held while out_ready is low; a new operand can be taken on the retiring edge.
module nibble_seq_adder
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic               clk,
    input logic               rst,
    nibble_seq_adder_if.slave bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             cin_q;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             accept;
    logic             last;

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign last          = (state == RUN) && (idx == LAST_IDX);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = RUN;
            end
            RUN: begin
                // Adder inputs come from registers only, so the adder return never loops back.
                bus.add_a   = op_a[idx * NIBBLE_W +: NIBBLE_W];
                bus.add_b   = op_b[idx * NIBBLE_W +: NIBBLE_W];
                bus.add_cin = (idx == '0) ? cin_q : carry_q;
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = bus.in_valid ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            cin_q   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_a  <= bus.in_a;
                op_b  <= bus.in_b;
                cin_q <= bus.in_cin;
                idx   <= '0;
            end
            if (state == RUN) begin
                sum_q[idx * NIBBLE_W +: NIBBLE_W] <= bus.add_sum;
                carry_q <= bus.add_cout;
                if (last) begin
                    idx    <= '0;
                    cout_q <= bus.add_cout;
                    // Signed overflow: like-signed operands whose top-nibble sum flips sign.
                    ovf_q  <= (op_a[W-1] == op_b[W-1]) && (bus.add_sum[NIBBLE_W-1] != op_a[W-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Harness: nibble_seq_adder wired to adder_1c, checked against a plain-arithmetic model.
module tb_nibble_seq_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [W-1:0] last_sum;

    always #5 clk = ~clk;

    nibble_seq_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_seq_adder #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    adder_1c u_add (
        .a    (bus.add_a),
        .b    (bus.add_b),
        .cin  (bus.add_cin),
        .sum  (bus.add_sum),
        .cout (bus.add_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait (bounded) for in_ready and take the accept edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("start_in_ready", 32'(bus.in_ready), 1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 1);
    endtask

    // Walk the nibble cycles and compare with the arithmetic model; leaves the block in DONE.
    task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ovf;
        int           cin_i;
        full  = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        s     = full[W-1:0];
        ovf   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        for (int i = 0; i < NIBBLES; i++) begin
            cin_i = ((int'(a) % (1 << (4 * i))) + (int'(b) % (1 << (4 * i))) + int'(cin)) >> (4 * i);
            check("add_a", 32'(bus.add_a), (int'(a) >> (4 * i)) & 15);
            check("add_b", 32'(bus.add_b), (int'(b) >> (4 * i)) & 15);
            check("add_cin", 32'(bus.add_cin), cin_i);
            check("out_valid_run", 32'(bus.out_valid), 0);
            tick();
        end
        check("out_valid_done", 32'(bus.out_valid), 1);
        check("out_sum", 32'(bus.out_sum), 32'(s));
        check("out_cout", 32'(bus.out_cout), 32'(full[W]));
        check("out_ovf", 32'(bus.out_ovf), 32'(ovf));
        check("add_a_idle", 32'(bus.add_a), 0);
        last_sum = s;
    endtask

    // Hold the result for some stall cycles, then retire it with no new operands.
    task automatic retire(input int stall);
        bus.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_sum", 32'(bus.out_sum), 32'(last_sum));
            check("stall_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("retire_valid", 32'(bus.out_valid), 0);
        check("retire_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;

        // Reset asserted mid-cycle takes effect immediately.
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_sum", 32'(bus.out_sum), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_add_a", 32'(bus.add_a), 0);
        check("rst_add_b", 32'(bus.add_b), 0);
        check("rst_add_cin", 32'(bus.add_cin), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 1);

        start(16'h1234, 16'h0FFF, 1'b0);
        run_check(16'h1234, 16'h0FFF, 1'b0);
        check("basic_const", 32'(bus.out_sum), 32'h2233);
        retire(0);

        start(16'hFFFF, 16'h0001, 1'b0);
        run_check(16'hFFFF, 16'h0001, 1'b0);
        check("ripple_cout", 32'(bus.out_cout), 1);
        retire(1);

        start(16'h7FFF, 16'h0001, 1'b0);
        run_check(16'h7FFF, 16'h0001, 1'b0);
        check("ovf_const", 32'(bus.out_ovf), 1);
        retire(0);

        start(16'h0000, 16'h0000, 1'b1);
        run_check(16'h0000, 16'h0000, 1'b1);
        check("cin_const", 32'(bus.out_sum), 32'h0001);
        retire(0);

        // Backpressure with pending operands, then a same-edge retire-and-accept.
        start(16'h1111, 16'h2222, 1'b0);
        run_check(16'h1111, 16'h2222, 1'b0);
        bus.in_a     = 16'h5555;
        bus.in_b     = 16'h1111;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_sum", 32'(bus.out_sum), 32'h3333);
            check("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_a      = 16'h0001;
        bus.in_b      = 16'h0001;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_reaccept_busy", 32'(bus.busy), 1);
        run_check(16'h0001, 16'h0001, 1'b0);
        check("bp_const", 32'(bus.out_sum), 32'h0002);
        retire(0);

        // Reset in the middle of an operation discards it.
        start(16'hAAAA, 16'h5555, 1'b0);
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_sum", 32'(bus.out_sum), 0);
        check("midrst_add_a", 32'(bus.add_a), 0);
        check("midrst_valid", 32'(bus.out_valid), 0);
        #2 rst = 1'b0;
        tick();
        start(16'h0003, 16'h0004, 1'b0);
        run_check(16'h0003, 16'h0004, 1'b0);
        check("midrst_const", 32'(bus.out_sum), 32'h0007);
        retire(0);

        // Random operands, random stalls, some back-to-back same-edge accepts.
        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            start(ra, rb, rc);
            run_check(ra, rb, rc);
            if ($urandom_range(0, 1) == 1) bus.out_ready = 1'b1;
            else retire($urandom_range(0, 3));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("final_idle", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_seq_adder.md
Name: nibble_seq_adder

Overview:
- Multi-nibble add controller. Sits directly upstream and downstream of the 4-bit ripple adder (`adder_1c`).
- Accepts two W-bit operands and a carry-in over a valid/ready handshake. Drives the adder one nibble per cycle, LSB nibble first, and chains carry-out back into carry-in through a register.
- Collects the returned sums and presents a W-bit result, carry-out and signed overflow on an output valid/ready handshake.
- Lets the existing 4-bit adder serve wider datapaths without widening it.

Parameters:
- NIBBLES, 4, number of 4-bit slices; W = 4*NIBBLES (default 16).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in to nibble 0.
- add_a  out  4  nibble of A to adder.
- add_b  out  4  nibble of B to adder.
- add_cin  out  1  carry to adder.
- add_sum  in  4  adder sum, combinational return.
- add_cout  in  1  adder carry-out, combinational return.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_sum  out  W  result.
- out_cout  out  1  final carry-out.
- out_ovf  out  1  two's-complement overflow.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: one clock `clk`; `rst` is asynchronous and active-high and may assert at any time, including mid-operation. It forces:
  - state=IDLE, idx=0, carry_q=0;
  - op_a/op_b/cin registers and out_sum cleared to 0;
  - out_cout=0, out_ovf=0, out_valid=0, busy=0;
  - add_a/add_b/add_cin=0;
  - in_ready=1 once state is IDLE.
  - Any in-flight operation is discarded.
- States:
  - IDLE: no operation.
  - RUN: sequencing nibbles.
  - DONE: result held.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from state and out_ready only.
- Accept = in_valid & in_ready on a rising edge. It latches op_a=in_a, op_b=in_b, cin_q=in_cin, sets idx=0 and moves to RUN.
- RUN, cycle for nibble idx:
  - add_a = op_a[4*idx+:4], add_b = op_b[4*idx+:4].
  - add_cin = (idx==0) ? cin_q : carry_q.
  - On the edge: out_sum[4*idx+:4] <= add_sum, carry_q <= add_cout, idx++.
- End of RUN: on the edge where idx==NIBBLES-1:
  - out_cout <= add_cout;
  - out_ovf <= (op_a[W-1]==op_b[W-1]) & (add_sum[3]!=op_a[W-1]);
  - state -> DONE, out_valid=1.
- Outside RUN: add_a/add_b/add_cin = 0.
- Latency: accept edge k; result registered and out_valid high after edge k+NIBBLES. Throughput is one operation per NIBBLES+1 cycles under continuous ready.
- DONE:
  - out_sum/out_cout/out_ovf held stable while out_valid & !out_ready. Any number of stall cycles allowed.
  - in_valid is ignored while stalled (in_ready=0).
  - out_valid & out_ready & in_valid in the same cycle: result retired and new operands accepted on the same edge. Next state RUN with out_valid=0.
  - out_valid & out_ready & !in_valid: next state IDLE.
- out_sum changes only during RUN. During RUN, out_sum may hold partially updated nibbles and is not valid; consumers qualify with out_valid.
- in_a/in_b/in_cin changes during RUN or DONE have no effect.
- NIBBLES=1 is legal: RUN lasts one cycle.
- No combinational path from add_sum/add_cout to add_a/add_b/add_cin. The add_* outputs depend only on registered state.

Decomposition:
- Package `nibble_add_pkg`: NIBBLE_W=4 constant and the state_t enum {IDLE, RUN, DONE}.
- No internal sub-module. `adder_1c` is instantiated beside this block at the parent level and wired to the add_* ports.
- The bench wraps both in a test harness.

Test Plan (NIBBLES=4, adder_1c connected):
- Reset: assert rst mid-clock -> immediately out_valid=0, out_sum=0x0000, busy=0, add_*=0; in_ready=1 after release.
- Basic add: 0x1234 + 0x0FFF, cin=0 -> add_a sequence 4,3,2,1 on consecutive cycles. Then out_valid after 4 edges with out_sum=0x2233, out_cout=0, out_ovf=0.
- Carry ripple: 0xFFFF + 0x0001, cin=0 -> carry_q=1 every nibble. Result out_sum=0x0000, out_cout=1, out_ovf=0.
- Overflow and cin: 0x7FFF + 0x0001 -> 0x8000, ovf=1, cout=0. Then 0x0000 + 0x0000 with cin=1 -> 0x0001, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0, no accept. Then out_ready=1 with in_valid=1 (0x0001+0x0001) -> same-edge accept; out_valid low for 4 cycles, then 0x0002.
- Reset mid-RUN: assert rst after 2 nibbles of 0xAAAA+0x5555 -> state IDLE, outputs zero. Next op 0x0003+0x0004 -> 0x0007 with correct latency.
